// File: rtl/data_memory_responder.sv
// data_memory_responder: handshaked load/store responder over word-organised storage
// with byte/half/word access and a programmable number of wait states.
module data_memory_responder #(
  parameter int DEPTH = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic error_q, error_d;
  logic [31:0] mem [DEPTH];
  logic accept, err, we;
  logic [AW-1:0] idx;
  logic [31:0] word, sh, ld, wd;
  logic [3:0] be;
  assign req_ready_o = reset_i && state_q == S_IDLE;
  assign rsp_valid_o = state_q == S_RESP;
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = error_q;
  assign accept = req_valid_i && req_ready_o;
  assign idx = req_addr_i[AW+1:2];
  assign err = req_size_i == 2'b11 || (req_size_i == 2'b01 && req_addr_i[0]) ||
               (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00) || |req_addr_i[31:AW+2];
  assign word = mem[idx];
  // Alignment is guaranteed for error-free halves, so one shift serves both sub-word sizes.
  assign sh = word >> {req_addr_i[1:0], 3'b000};
  assign ld = req_size_i == 2'b00 ? {{24{~req_unsigned_i & sh[7]}}, sh[7:0]} :
              req_size_i == 2'b01 ? {{16{~req_unsigned_i & sh[15]}}, sh[15:0]} : word;
  assign wd = req_size_i == 2'b00 ? {4{req_wdata_i[7:0]}} :
              req_size_i == 2'b01 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
  assign be = req_size_i == 2'b00 ? 4'b0001 << req_addr_i[1:0] :
              req_size_i == 2'b01 ? (req_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign we = accept && req_write_i && !err;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    error_d = error_q;
    if (accept) begin
      error_d = err;
      rdata_d = (err || req_write_i) ? 32'h0 : ld;
      cnt_d = CNT_LOAD;
      state_d = WAIT_CYCLES == 0 ? S_RESP : S_WAIT;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      state_d = cnt_q == 4'd0 ? S_RESP : S_WAIT;
    end else if (state_q == S_RESP && rsp_ready_i) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      cnt_q <= 4'd0;
      rdata_q <= 32'h0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (we) for (int i = 0; i < 4; i++) if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Responder end of the core's load/store request/response interface. Accepts one memory request at a time from the load/store side of the RISC-V softcore, performs a byte, halfword or word access on internal word-organised storage, and returns a response after a programmable number of wait states. Sits between the core's data path and the data storage, replacing the zero-latency combinational data memory once the core moves to a handshaked memory port.

## Interface
- DEPTH, 1024: storage size in 32-bit words; power of two.
- WAIT_CYCLES, 1: wait states between request acceptance and response valid; 0–15.
- clk_i  input  1  clock; all state changes on rising edge.
- reset_i  input  1  reset, asynchronous and active-low.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request this cycle.
- req_write_i  input  1  1 = store, 0 = load.
- req_addr_i  input  32  byte address.
- req_size_i  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned_i  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  requester accepts response.
- rsp_rdata_o  output  32  load data, extended to 32 bits; 0 for stores and errors.
- rsp_error_o  output  1  request was illegal, misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready_o = 1. On req_valid_i && req_ready_o (accept): evaluate request, latch result; go to WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT: req_ready_o = 0; down-counter loaded with WAIT_CYCLES−1 at accept; go to RESP when counter = 0.
- RESP: rsp_valid_o = 1, rsp_rdata_o/rsp_error_o stable. On rsp_ready_i go to IDLE; otherwise hold indefinitely.
- Error when any of: req_size_i = 11; halfword with addr[0] = 1; word with addr[1:0] ≠ 00; req_addr_i ≥ DEPTH*4. Error responses: rsp_error_o = 1, rsp_rdata_o = 0, storage unmodified.
- Word index = req_addr_i[log2(DEPTH)+1:2].
- Store: committed to storage at the accept edge. Byte writes lane addr[1:0] with wdata[7:0]; halfword writes lanes {addr[1],1}:{addr[1],0} with wdata[15:0]; word writes all lanes. Other lanes unchanged. Store response rdata = 0, error = 0.
- Load: storage read at accept (sees all previously committed stores). Byte lane addr[1:0] or half lane addr[1] selected, then sign- or zero-extended per req_unsigned_i; word returned unmodified (req_unsigned_i ignored).
- Storage contents are not reset; unwritten locations read undefined.

## Timing
- Reset asserted: state IDLE, req_ready_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_error_o = 0, counter = 0. req_ready_o = 1 from first cycle after deassertion.
- Accept in cycle N: rsp_valid_o first high in cycle N+1+WAIT_CYCLES.
- Response handshake in cycle M: IDLE and req_ready_o = 1 in cycle M+1; next accept at M+1 earliest. Throughput: one request per WAIT_CYCLES+2 cycles with rsp_ready_i held high.
- req_ready_o is purely state-decoded; never depends combinationally on req_valid_i.
- Request inputs sampled only at accept; changes afterwards ignored.
- Response outputs held constant while rsp_valid_o && !rsp_ready_i.
- Reset mid-operation (WAIT or RESP): pending response discarded, outputs to reset values; a store committed at accept remains in storage.

## Test plan
- Reset then idle: reset_i low 3 cycles -> req_ready_o = 0, rsp_valid_o = 0; after release req_ready_o = 1 next cycle, rsp_valid_o stays 0 with no request.
- Word store/load, WAIT_CYCLES = 1: store 0xDEADBEEF to 0x10, then load word 0x10 -> each response valid exactly 2 cycles after accept; load rdata = 0xDEADBEEF, error = 0.
- Sub-word: store word 0x00000000 to 0x20, store byte 0x80 to 0x22, store half 0xBEEF to 0x20 -> load word 0x20 = 0x0080BEEF; signed byte 0x22 = 0xFFFFFF80; unsigned byte 0x22 = 0x00000080; signed half 0x20 = 0xFFFFBEEF.
- Errors: word load 0x02, half store 0x01, size 11 at 0x00, word load at DEPTH*4 -> each rsp_error_o = 1, rdata = 0; word at 0x00 unchanged after the store attempt.
- Backpressure: hold rsp_ready_i = 0 for 5 cycles on a load -> rsp_valid_o and rdata stable 5+ cycles, req_ready_o = 0, req_valid_i pulses ignored; release -> IDLE next cycle.
- Reset mid-WAIT with WAIT_CYCLES = 4: accept store 0x12345678 to 0x40, assert reset in WAIT -> no response ever issued; after release load 0x40 returns 0x12345678.
